// File: rtl/param_mem_slave.sv
// Parametrised single-port memory slave: synchronous write, RD_LAT-stage read pipeline, out-of-range error flag.
// Read latency RD_LAT cycles, fully pipelined; no backpressure, one request per cycle.
module param_mem_slave #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              read,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic              wr_req;
  logic              rd_req;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_dat;

  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] err_q;
  logic [DATA_W-1:0] dat_q [RD_LAT];

  assign in_range = ({1'b0, addr} < DEPTH_L);
  assign wr_req   = enable && !read;
  assign rd_req   = enable && read;
  assign idx      = addr[IDX_W-1:0];
  assign rd_dat   = in_range ? mem[idx] : '0;

  // Array has no reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && wr_req && in_range) begin
      mem[idx] <= wdata;
    end
  end

  // Stage 0 captures the array at the request edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q[0] <= 1'b0;
      err_q[0] <= 1'b0;
      dat_q[0] <= '0;
    end else begin
      vld_q[0] <= rd_req;
      if (rd_req) begin
        dat_q[0] <= rd_dat;
        err_q[0] <= !in_range;
      end
    end
  end

  // Later stages only load on a valid word so the output holds between strobes.
  for (genvar s = 1; s < RD_LAT; s++) begin : g_stage
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q[s] <= 1'b0;
        err_q[s] <= 1'b0;
        dat_q[s] <= '0;
      end else begin
        vld_q[s] <= vld_q[s-1];
        if (vld_q[s-1]) begin
          dat_q[s] <= dat_q[s-1];
          err_q[s] <= err_q[s-1];
        end
      end
    end
  end

  assign data       = dat_q[RD_LAT-1];
  assign data_valid = vld_q[RD_LAT-1];
  assign err        = err_q[RD_LAT-1] && vld_q[RD_LAT-1];

endmodule

// File: tb/tb_param_mem_slave.sv
// Bench for param_mem_slave: instance A (8-bit, DEPTH=200, RD_LAT=1) and instance B (16-bit, RD_LAT=3).
module tb_param_mem_slave;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_en, a_rd;
  logic [7:0] a_addr, a_wd, a_data;
  logic       a_vld, a_err;

  logic        b_en, b_rd;
  logic [7:0]  b_addr;
  logic [15:0] b_wd, b_data;
  logic        b_vld, b_err;

  param_mem_slave #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .RD_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(a_en), .read(a_rd), .addr(a_addr),
    .wdata(a_wd), .data(a_data), .data_valid(a_vld), .err(a_err)
  );

  param_mem_slave #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .RD_LAT(3)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(b_en), .read(b_rd), .addr(b_addr),
    .wdata(b_wd), .data(b_data), .data_valid(b_vld), .err(b_err)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive_a(input logic en, input logic rd, input logic [7:0] ad, input logic [7:0] wd);
    a_en = en; a_rd = rd; a_addr = ad; a_wd = wd;
  endtask

  task automatic drive_b(input logic en, input logic rd, input logic [7:0] ad, input logic [15:0] wd);
    b_en = en; b_rd = rd; b_addr = ad; b_wd = wd;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_b(input string name, input logic vld, input logic [15:0] dat, input logic e);
    chk({name, " vld"}, {15'd0, b_vld}, {15'd0, vld});
    chk({name, " data"}, b_data, dat);
    chk({name, " err"}, {15'd0, b_err}, {15'd0, e});
  endtask

  task automatic chk_a(input string name, input logic vld, input logic [7:0] dat, input logic e);
    chk({name, " vld"}, {15'd0, a_vld}, {15'd0, vld});
    chk({name, " data"}, {8'd0, a_data}, {8'd0, dat});
    chk({name, " err"}, {15'd0, a_err}, {15'd0, e});
  endtask

  typedef struct {
    logic       en;
    logic       rd;
    logic [7:0] addr;
    logic [7:0] wd;
    logic       exp_vld;
    logic [7:0] exp_dat;
    logic       exp_err;
  } vec_t;

  vec_t tbl [13];

  initial begin
    // Each row: request, then outputs seen in the cycle after its edge (RD_LAT=1).
    tbl[0]  = '{1'b1, 1'b0, 8'd7,   8'hA5, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 8'd7,   8'h00, 1'b1, 8'hA5, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 8'd0,   8'h00, 1'b0, 8'hA5, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 8'd199, 8'h42, 1'b0, 8'hA5, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'd250, 8'hFF, 1'b0, 8'hA5, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 8'd250, 8'h00, 1'b1, 8'h00, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 8'd199, 8'h00, 1'b1, 8'h42, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 8'd5,   8'h10, 1'b0, 8'h42, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 8'd5,   8'h00, 1'b1, 8'h10, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 8'd5,   8'h20, 1'b0, 8'h10, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 8'd5,   8'h30, 1'b0, 8'h10, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 8'd5,   8'h00, 1'b1, 8'h30, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 8'd7,   8'h55, 1'b0, 8'h30, 1'b0};

    drive_a(1'b0, 1'b0, 8'd0, 8'd0);
    drive_b(1'b0, 1'b0, 8'd0, 16'd0);
    #2;
    chk_a("reset A", 1'b0, 8'h00, 1'b0);
    chk_b("reset B", 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive_a(tbl[i].en, tbl[i].rd, tbl[i].addr, tbl[i].wd);
      cyc();
      chk_a($sformatf("vec%0d", i), tbl[i].exp_vld, tbl[i].exp_dat, tbl[i].exp_err);
    end

    // Enable gating: random traffic with enable low must not strobe or write.
    for (int i = 0; i < 10; i++) begin
      drive_a(1'b0, 1'($urandom), 8'($urandom_range(0, 255)), 8'($urandom));
      cyc();
      chk($sformatf("idle%0d vld", i), {15'd0, a_vld}, 16'd0);
    end
    drive_a(1'b1, 1'b1, 8'd7, 8'd0);   cyc(); chk_a("readback 7", 1'b1, 8'hA5, 1'b0);
    drive_a(1'b1, 1'b1, 8'd199, 8'd0); cyc(); chk_a("readback 199", 1'b1, 8'h42, 1'b0);
    drive_a(1'b1, 1'b1, 8'd5, 8'd0);   cyc(); chk_a("readback 5", 1'b1, 8'h30, 1'b0);
    drive_a(1'b0, 1'b0, 8'd0, 8'd0);

    // Pipelined reads on B.
    drive_b(1'b1, 1'b0, 8'd0, 16'h1111); cyc();
    drive_b(1'b1, 1'b0, 8'd1, 16'h2222); cyc();
    drive_b(1'b1, 1'b0, 8'd2, 16'h3333); cyc();
    drive_b(1'b1, 1'b0, 8'd5, 16'h0010); cyc();
    drive_b(1'b1, 1'b1, 8'd0, 16'h0);    cyc(); chk_b("pipe e0", 1'b0, 16'h0000, 1'b0);
    drive_b(1'b1, 1'b1, 8'd1, 16'h0);    cyc(); chk_b("pipe e1", 1'b0, 16'h0000, 1'b0);
    drive_b(1'b1, 1'b1, 8'd2, 16'h0);    cyc(); chk_b("pipe e2", 1'b1, 16'h1111, 1'b0);
    drive_b(1'b0, 1'b0, 8'd0, 16'h0);    cyc(); chk_b("pipe e3", 1'b1, 16'h2222, 1'b0);
    cyc(); chk_b("pipe e4", 1'b1, 16'h3333, 1'b0);
    cyc(); chk_b("pipe e5", 1'b0, 16'h3333, 1'b0);

    // Write-after-read returns old data; read-after-write returns new data.
    drive_b(1'b1, 1'b1, 8'd5, 16'h0);    cyc();
    drive_b(1'b1, 1'b0, 8'd5, 16'h0020); cyc();
    drive_b(1'b1, 1'b0, 8'd5, 16'h0030); cyc(); chk_b("war", 1'b1, 16'h0010, 1'b0);
    drive_b(1'b1, 1'b1, 8'd5, 16'h0);    cyc(); chk_b("raw e0", 1'b0, 16'h0010, 1'b0);
    drive_b(1'b0, 1'b0, 8'd0, 16'h0);    cyc(); chk_b("raw e1", 1'b0, 16'h0010, 1'b0);
    cyc(); chk_b("raw e2", 1'b1, 16'h0030, 1'b0);

    // Reset mid-flight: in-flight read on B is dropped, writes during reset are ignored.
    drive_b(1'b1, 1'b1, 8'd1, 16'h0); cyc();
    drive_b(1'b0, 1'b0, 8'd0, 16'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    drive_a(1'b1, 1'b0, 8'd7, 8'h77);
    #1;
    chk_b("async rst B", 1'b0, 16'h0000, 1'b0);
    chk_a("async rst A", 1'b0, 8'h00, 1'b0);
    cyc();
    cyc();
    rst_n = 1'b1;
    drive_a(1'b0, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("post rst vld%0d", i), {15'd0, b_vld}, 16'd0);
    end
    drive_a(1'b1, 1'b1, 8'd7, 8'd0); cyc(); chk_a("no wr in rst", 1'b1, 8'hA5, 1'b0);
    drive_a(1'b0, 1'b0, 8'd0, 8'd0); cyc(); chk_a("strobe 1 cyc", 1'b0, 8'hA5, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/param_mem_slave.md
# param_mem_slave

Parametrised single-port synchronous memory slave on the `read`/`enable`/`addr`/`data` bus. It generalises the fixed 8-bit, zero-latency slave to configurable data width, address width, depth and read latency, and adds write data, a read-valid strobe and an out-of-range error flag. It sits behind the bus interface's `dut` side and is driven by the testbench through the interface clocking block.

## Interface
- `DATA_W`, 8: data bus width in bits, 1..64.
- `ADDR_W`, 8: address bus width in bits, 1..16.
- `DEPTH`, 256: number of words, 1..2**ADDR_W.
- `RD_LAT`, 1: read latency in cycles, 1..4.

Ports:
- `clk`  in  1  Single clock; all logic is rising-edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `enable`  in  1  Request qualifier; no action when low.
- `read`  in  1  1 = read request, 0 = write request (when `enable` is high).
- `addr`  in  ADDR_W  Word address.
- `wdata`  in  DATA_W  Write data, sampled with a write request.
- `data`  out  DATA_W  Read data.
- `data_valid`  out  1  One-cycle strobe marking `data` as valid.
- `err`  out  1  Out-of-range flag, aligned with `data_valid`.

## Operation
- Storage: `DEPTH` x `DATA_W` array, single port. Contents are not cleared by reset and are X until written.
- Write: at a rising edge with `enable`=1 and `read`=0, if `addr` < `DEPTH`, then `mem[addr]` <= `wdata`. No response strobe is produced.
- Write with `addr` >= `DEPTH`: the array is unchanged and no strobe is produced. Out-of-range writes are silently dropped.
- Read: at a rising edge with `enable`=1 and `read`=1, the request enters an `RD_LAT`-stage pipeline. Each stage holds a valid bit, the data word and the error bit.
  - The array is read at the request edge.
  - Stages 2..`RD_LAT` are plain registers.
- Read with `addr` >= `DEPTH`: the result is `data`=0 and `err`=1 at the response cycle.
- Back-to-back reads are fully pipelined, one per cycle. Responses return in issue order with no bubbles.
- Read-after-write: a write at edge N followed by a read of the same address at edge N+1 returns the new data.
- Write-after-read: a read at edge N followed by a write at edge N+1 returns the old data, because the array is sampled at edge N.
- A read and a write in the same cycle is impossible, since `read` selects one.
- Output holding: `data` holds its last value when `data_valid`=0. `err` is 0 whenever `data_valid`=0.
- `enable`=0: `read`, `addr` and `wdata` are ignored and the pipeline keeps draining.

## Timing
- Reset (`rst_n` low, asynchronous): `data`=0, `data_valid`=0, `err`=0 immediately. All pipeline valid bits are cleared.
- Reset mid-operation: in-flight reads are discarded and never produce a strobe. No array write occurs while `rst_n` is low.
- Release of `rst_n` is synchronised by the environment. The first request is accepted at the first rising edge with `rst_n` high.
- Read latency: a request at edge N produces `data_valid`=1 and `data`/`err` during the cycle after edge N+`RD_LAT`-1, i.e. registered at edge N+`RD_LAT`-1.
  - For `RD_LAT`=1, the response is registered at the same edge the request is sampled and is visible for the following cycle.
- `data_valid` is high for exactly one cycle per accepted read.
- Inputs must be stable around the rising edge. The bench drives them with output skew after the edge and samples `data`/`data_valid`/`err` with input skew before the next edge.

## Test plan
- Reset check: assert `rst_n`=0 mid-cycle -> `data`=0, `data_valid`=0 and `err`=0 asynchronously. A read issued one cycle before reset with `RD_LAT`=3 never strobes.
- Write/read basic (DATA_W=8, RD_LAT=1): write 0xA5 to addr 7, then read addr 7 -> one cycle later `data`=0xA5, `data_valid`=1, `err`=0. `data_valid` returns to 0 on the next cycle.
- Pipelined reads (RD_LAT=3, DATA_W=16): write 0x1111, 0x2222, 0x3333 to addrs 0..2, then read 0,1,2 on consecutive edges -> three consecutive strobes starting 3 cycles after the first read, carrying 0x1111, 0x2222, 0x3333 in order.
- Read-after-write and write-after-read hazards: with addr 5 = 0x10, read 5 then write 0x20 at the next edge -> the response is 0x10. Then write 0x30 followed by read 5 at the next edge -> the response is 0x30.
- Out of range (DEPTH=200, ADDR_W=8): write 0xFF to addr 250, then read 250 -> `data`=0, `err`=1, `data_valid`=1. A subsequent read of addr 199 (previously written with 0x42) -> 0x42 with `err`=0.
- Idle/enable gating: toggle `read`, `addr` and `wdata` with `enable`=0 for 10 cycles -> no strobes and the array contents are unchanged, verified by reading back.
